// File: rtl/eq_gain_scheduler.sv
// EQ gain scheduler: holds per-band target and applied gains and ramps one band
// by one step per frame tick, issuing each step to the DSP over valid/ready.
module eq_gain_scheduler #(
  parameter int NBAND    = 7,
  parameter int GAIN_W   = 16,
  parameter int GAIN_MAX = 12,
  parameter int GAIN_MIN = -11
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_tgt_we,
  input  logic [2:0]               i_tgt_band,
  input  logic signed [GAIN_W-1:0] i_tgt_gain,
  input  logic                     i_clear,
  input  logic                     i_frame,
  output logic                     o_wr_valid,
  output logic [2:0]               o_wr_band,
  output logic signed [GAIN_W-1:0] o_wr_gain,
  input  logic                     i_wr_ready,
  output logic                     o_busy,
  output logic [NBAND-1:0]         o_pending
);
  // state   | meaning
  // S_IDLE  | waiting for an accepted frame tick
  // S_SCAN  | walking bands from rr, one per cycle, looking for cur != tgt
  // S_ISSUE | holding one step write until the DSP accepts it
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_ISSUE} state_t;

  localparam int BW = 3;
  localparam logic [BW-1:0]        LAST  = BW'(NBAND - 1);
  localparam logic signed [GAIN_W-1:0] G_MAX = GAIN_W'(GAIN_MAX);
  localparam logic signed [GAIN_W-1:0] G_MIN = GAIN_W'(GAIN_MIN);
  localparam logic signed [GAIN_W-1:0] G_ONE = GAIN_W'(1);

  state_t                   state, state_d;
  logic [BW-1:0]            rr, rr_d, idx, idx_d, cnt, cnt_d, band_d;
  logic signed [GAIN_W-1:0] gain_d, tgt_clamped, cur_sel, tgt_sel;
  logic                     valid_d, frame_acc, commit;
  logic signed [GAIN_W-1:0] tgt [NBAND];
  logic signed [GAIN_W-1:0] cur [NBAND];

  function automatic logic [BW-1:0] nxt(input logic [BW-1:0] b);
    return (b == LAST) ? '0 : b + 1'b1;
  endfunction

  assign tgt_clamped = (i_tgt_gain > G_MAX) ? G_MAX :
                       (i_tgt_gain < G_MIN) ? G_MIN : i_tgt_gain;

  for (genvar b = 0; b < NBAND; b++) begin : g_pend
    assign o_pending[b] = (cur[b] != tgt[b]);
  end
  assign o_busy = |o_pending;

  always_comb begin
    cur_sel = cur[idx];
    tgt_sel = tgt[idx];
    state_d = state;
    rr_d    = rr;
    idx_d   = idx;
    cnt_d   = cnt;
    valid_d = o_wr_valid;
    band_d  = o_wr_band;
    gain_d  = o_wr_gain;
    commit  = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_acc) begin
          state_d = S_SCAN;
          idx_d   = rr;
          cnt_d   = '0;
        end
      end
      S_SCAN: begin
        if (cur_sel != tgt_sel) begin
          valid_d = 1'b1;
          band_d  = idx;
          gain_d  = (tgt_sel > cur_sel) ? cur_sel + G_ONE : cur_sel - G_ONE;
          state_d = S_ISSUE;
        end else begin
          idx_d = nxt(idx);
          cnt_d = cnt + 1'b1;
          if (cnt == LAST) state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (i_wr_ready) begin
          commit  = 1'b1;
          valid_d = 1'b0;
          rr_d    = nxt(o_wr_band);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // frame ticks are registered once, and only while idle, so busy-time ticks drop
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      rr         <= '0;
      idx        <= '0;
      cnt        <= '0;
      frame_acc  <= 1'b0;
      o_wr_valid <= 1'b0;
      o_wr_band  <= '0;
      o_wr_gain  <= '0;
    end else begin
      state      <= state_d;
      rr         <= rr_d;
      idx        <= idx_d;
      cnt        <= cnt_d;
      frame_acc  <= i_frame && (state == S_IDLE) && !frame_acc;
      o_wr_valid <= valid_d;
      o_wr_band  <= band_d;
      o_wr_gain  <= gain_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int b = 0; b < NBAND; b++) begin
        tgt[b] <= '0;
        cur[b] <= '0;
      end
    end else begin
      if (i_clear) begin
        for (int b = 0; b < NBAND; b++) tgt[b] <= '0;
      end else if (i_tgt_we && ({1'b0, i_tgt_band} < 4'(NBAND))) begin
        tgt[i_tgt_band] <= tgt_clamped;
      end
      if (commit) cur[o_wr_band] <= o_wr_gain;
    end
  end
endmodule

// File: tb/tb_eq_gain_scheduler.sv
// Scoreboard bench for eq_gain_scheduler: a per-band gain model predicts each
// DSP write and its timing; a negedge monitor pops and checks every handshake.
module tb_eq_gain_scheduler;
  localparam int NBAND = 7;
  localparam int GAIN_W = 16;

  logic i_clk = 0, i_rst_n = 0, i_tgt_we = 0, i_clear = 0, i_frame = 0, i_wr_ready = 0;
  logic [2:0] i_tgt_band = '0;
  logic signed [GAIN_W-1:0] i_tgt_gain = '0;
  logic o_wr_valid, o_busy;
  logic [2:0] o_wr_band;
  logic signed [GAIN_W-1:0] o_wr_gain;
  logic [NBAND-1:0] o_pending;

  eq_gain_scheduler dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_tgt_we(i_tgt_we), .i_tgt_band(i_tgt_band),
    .i_tgt_gain(i_tgt_gain), .i_clear(i_clear), .i_frame(i_frame),
    .o_wr_valid(o_wr_valid), .o_wr_band(o_wr_band), .o_wr_gain(o_wr_gain),
    .i_wr_ready(i_wr_ready), .o_busy(o_busy), .o_pending(o_pending)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {int band; int gain; int cyc;} exp_t;
  exp_t exp_q[$];
  int tgt_m[NBAND];
  int cur_m[NBAND];
  int rr_m = 0;
  int total = 0, bad = 0, hs_count = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic model_reset();
    for (int b = 0; b < NBAND; b++) begin
      tgt_m[b] = 0;
      cur_m[b] = 0;
    end
    rr_m = 0;
    exp_q.delete();
  endtask

  // one frame: first band from rr whose applied gain is off target moves one step
  task automatic model_frame();
    for (int k = 0; k < NBAND; k++) begin
      int b = (rr_m + k) % NBAND;
      if (cur_m[b] != tgt_m[b]) begin
        exp_t e;
        e.band = b;
        e.gain = cur_m[b] + ((tgt_m[b] > cur_m[b]) ? 1 : -1);
        e.cyc = cyc + 3 + k;
        exp_q.push_back(e);
        cur_m[b] = e.gain;
        rr_m = (b + 1) % NBAND;
        return;
      end
    end
  endtask

  task automatic model_tgt(input int band, input int gain, input bit clr);
    if (clr) begin
      for (int b = 0; b < NBAND; b++) tgt_m[b] = 0;
    end else if (band < NBAND) begin
      tgt_m[band] = (gain > 12) ? 12 : (gain < -11) ? -11 : gain;
    end
  endtask

  task automatic set_tgt(input int band, input int gain, input bit clr);
    i_tgt_we = 1;
    i_tgt_band = 3'(band);
    i_tgt_gain = GAIN_W'(gain);
    i_clear = clr;
    model_tgt(band, gain, clr);
    tick();
    i_tgt_we = 0;
    i_clear = 0;
  endtask

  task automatic frame(input bit rnd_ready);
    bit done = 0;
    i_frame = 1;
    model_frame();
    tick();
    i_frame = 0;
    for (int n = 0; n < 200; n++) begin
      i_wr_ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
      if (n >= 12 && exp_q.size() == 0) begin
        done = 1;
        break;
      end
      tick();
    end
    if (!done) begin
      chk("drain_timeout", 0, 1);
      exp_q.delete();
    end
  endtask

  task automatic check_pending(input string name);
    logic [NBAND-1:0] v;
    for (int b = 0; b < NBAND; b++) v[b] = (cur_m[b] != tgt_m[b]);
    chk({name, "_pending"}, int'(o_pending), int'(v));
    chk({name, "_busy"}, int'(o_busy), int'(|v));
  endtask

  task automatic do_reset();
    i_rst_n = 0;
    #1;
    chk("rst_valid", int'(o_wr_valid), 0);
    chk("rst_band", int'(o_wr_band), 0);
    chk("rst_gain", int'(o_wr_gain), 0);
    model_reset();
    tick();
    tick();
    i_rst_n = 1;
    tick();
    check_pending("rst");
  endtask

  bit prev_v = 0;
  int prev_band = 0, prev_gain = 0;
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      prev_v = 0;
    end else begin
      if (o_wr_valid && !prev_v) begin
        if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
        else chk("valid_latency_cycle", cyc, exp_q[0].cyc);
      end
      if (o_wr_valid && prev_v) begin
        chk("hold_band", int'(o_wr_band), prev_band);
        chk("hold_gain", int'(o_wr_gain), prev_gain);
      end
      if (o_wr_valid && i_wr_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("write_band", int'(o_wr_band), e.band);
          chk("write_gain", int'(o_wr_gain), e.gain);
        end
      end
      prev_v = o_wr_valid;
      prev_band = int'(o_wr_band);
      prev_gain = int'(o_wr_gain);
    end
  end

  initial begin
    int hs0;
    bit seen;
    model_reset();
    tick();
    do_reset();

    // idle after reset: frames produce nothing
    for (int i = 0; i < 10; i++) frame(0);
    check_pending("idle");

    // single-band ramp on band 2
    hs0 = hs_count;
    set_tgt(2, 3, 0);
    check_pending("ramp_start");
    for (int i = 0; i < 4; i++) frame(0);
    chk("ramp_writes", hs_count - hs0, 3);
    check_pending("ramp_end");

    // clamping and out-of-range band
    set_tgt(1, 20, 0);
    for (int i = 0; i < 14; i++) frame(1);
    check_pending("clamp_hi");
    set_tgt(1, -30, 0);
    for (int i = 0; i < 25; i++) frame(1);
    check_pending("clamp_lo");
    set_tgt(7, 5, 0);
    check_pending("bad_band");
    frame(0);

    // round-robin between bands 0 and 3
    do_reset();
    set_tgt(0, 2, 0);
    set_tgt(3, 2, 0);
    for (int i = 0; i < 5; i++) frame(0);
    check_pending("rr");

    // backpressure with dropped frames and a reversing target on the band in flight
    set_tgt(5, 2, 0);
    i_wr_ready = 0;
    i_frame = 1;
    model_frame();
    tick();
    i_frame = 0;
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (o_wr_valid) seen = 1;
      else tick();
    end
    chk("bp_valid_seen", int'(seen), 1);
    hs0 = hs_count;
    for (int n = 0; n < 8; n++) begin
      i_frame = (n == 2 || n == 5);
      if (n == 4) begin
        i_tgt_we = 1;
        i_tgt_band = 3'd5;
        i_tgt_gain = -16'sd3;
        model_tgt(5, -3, 0);
      end
      tick();
      i_frame = 0;
      i_tgt_we = 0;
      chk("bp_valid_held", int'(o_wr_valid), 1);
    end
    i_wr_ready = 1;
    for (int n = 0; n < 20; n++) tick();
    chk("bp_handshakes", hs_count - hs0, 1);
    for (int i = 0; i < 6; i++) frame(1);
    check_pending("bp_end");

    // clear wins over a simultaneous target write; cur ramps back down
    do_reset();
    set_tgt(4, 5, 0);
    for (int i = 0; i < 3; i++) frame(0);
    set_tgt(4, 6, 1);
    check_pending("clear");
    for (int i = 0; i < 4; i++) frame(1);
    check_pending("clear_end");

    // randomized traffic
    for (int it = 0; it < 150; it++) begin
      int r = $urandom_range(0, 15);
      if (r < 5) set_tgt($urandom_range(0, 7), $urandom_range(0, 60) - 30, ($urandom % 16) == 0);
      else frame(1);
      if (it % 10 == 0) check_pending("rand");
    end

    // reset while a write is held
    set_tgt(6, 1, 0);
    set_tgt(6, 1, 0);
    i_wr_ready = 0;
    if (cur_m[6] == tgt_m[6]) set_tgt(6, cur_m[6] > 0 ? -5 : 5, 0);
    for (int b = 0; b < NBAND; b++) if (b != 6) set_tgt(b, cur_m[b], 0);
    i_frame = 1;
    model_frame();
    tick();
    i_frame = 0;
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (o_wr_valid) seen = 1;
      else tick();
    end
    chk("rst_issue_valid_seen", int'(seen), 1);
    do_reset();
    frame(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
